// File: rtl/reg_file_host_pkg.sv
// Shared constants for the register-file host: default opcodes, FSM states
// and the error codes reported on err_code.
package reg_file_host_pkg;

  localparam logic [7:0] RF_WR_OP = 8'hAA;
  localparam logic [7:0] RF_RD_OP = 8'hBB;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WRITE,
    READ,
    CAPTURE,
    SEND
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_OP   = 2'b01,
    ERR_ADDR = 2'b10,
    ERR_TO   = 2'b11
  } err_e;

endpackage

// File: rtl/rf_frame_timer.sv
// Inter-byte idle timer: counts enabled cycles and pulses expired_o on the
// TIMEOUT-th consecutive enabled cycle.
module rf_frame_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expired_o) cnt_d = '0;
    else if (enable_i)        cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reg_file_host.sv
// Byte-serial command frames in (opcode, addr[, data]) -> single-cycle
// register-file strobes; read data returned as one byte on the output stream.
module reg_file_host
  import reg_file_host_pkg::*;
#(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_OP      = DATA_WIDTH'(RF_WR_OP),
  parameter logic [DATA_WIDTH-1:0] RD_OP      = DATA_WIDTH'(RF_RD_OP),
  parameter int                    TIMEOUT    = 255
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            err_code
);

  state_e                state_q, state_d;
  logic                  wr_flag_q, wr_flag_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  accept, in_frame, expired;

  // Address byte is legal only when every bit above the register index is 0.
  function automatic logic addr_legal(input logic [DATA_WIDTH-1:0] b);
    return (b >> ADDR_WIDTH) == '0;
  endfunction

  assign accept   = in_valid && in_ready;
  assign in_frame = (state_q == GET_ADDR) || (state_q == GET_DATA);

  rf_frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (CLK),
    .rst_i     (RST),
    .enable_i  (in_frame && !accept),
    .clear_i   (!in_frame || accept),
    .expired_o (expired)
  );

  always_comb begin
    state_d   = state_q;
    wr_flag_d = wr_flag_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    WrEn      = 1'b0;
    RdEn      = 1'b0;
    err       = 1'b0;
    err_code  = ERR_NONE;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          if (in_data == WR_OP) begin
            state_d   = GET_ADDR;
            wr_flag_d = 1'b1;
          end else if (in_data == RD_OP) begin
            state_d   = GET_ADDR;
            wr_flag_d = 1'b0;
          end else begin
            err      = 1'b1;
            err_code = ERR_OP;
          end
        end
      end
      GET_ADDR: begin
        in_ready = 1'b1;
        if (accept) begin
          addr_d = in_data;
          if (wr_flag_q)              state_d = GET_DATA;
          else if (addr_legal(in_data)) state_d = READ;
          else begin
            state_d  = IDLE;
            err      = 1'b1;
            err_code = ERR_ADDR;
          end
        end else if (expired) begin
          state_d  = IDLE;
          err      = 1'b1;
          err_code = ERR_TO;
        end
      end
      GET_DATA: begin
        in_ready = 1'b1;
        // The data byte is consumed even for a bad address to keep framing.
        if (accept) begin
          wdata_d = in_data;
          if (addr_legal(addr_q)) state_d = WRITE;
          else begin
            state_d  = IDLE;
            err      = 1'b1;
            err_code = ERR_ADDR;
          end
        end else if (expired) begin
          state_d  = IDLE;
          err      = 1'b1;
          err_code = ERR_TO;
        end
      end
      WRITE: begin
        WrEn    = 1'b1;
        state_d = IDLE;
      end
      READ: begin
        RdEn    = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        rdata_d = RdData;
        state_d = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_flag_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_flag_q <= wr_flag_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  assign Address  = addr_q[ADDR_WIDTH-1:0];
  assign WrData   = wdata_q;
  assign out_data = rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_reg_file_host.sv
// Directed + randomized frames checked cycle by cycle against a frame-level
// model (expected register contents and per-frame latency schedule).
module tb_reg_file_host;

  localparam logic [7:0] WR = 8'hAA;
  localparam logic [7:0] RD = 8'hBB;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       WrEn, RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] RdData = 8'h00;
  logic       busy, err;
  logic [1:0] err_code;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_mem [16] = '{default: 8'h00};
  logic [7:0] rf_mem  [16] = '{default: 8'h00};

  reg_file_host dut (
    .CLK(CLK), .RST(RST),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 CLK = ~CLK;

  // Register file: data valid the cycle after RdEn, garbage otherwise.
  always @(posedge CLK) begin
    if (WrEn) rf_mem[Address] <= WrData;
    RdData <= RdEn ? rf_mem[Address] : 8'($urandom);
  end

  always @(negedge CLK) begin
    if (!RST) begin
      checks++;
      assert (!(WrEn && RdEn)) else begin
        errors++;
        $error("FAIL strobe_excl observed WrEn=%0b RdEn=%0b expected not both", WrEn, RdEn);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_wait(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("gap_state", {in_ready, busy, err}, 3'b110);
      step();
    end
  endtask

  // One frame driven with optional inter-byte gaps and output back-pressure.
  task automatic run_frame(input logic [7:0] op, input logic [7:0] addr,
                           input logic [7:0] data, input int ga, input int gd,
                           input int stall);
    bit legal;
    legal = (addr < 8'd16);
    in_valid = 1'b1; in_data = op; #1;
    chk("op_rdy", in_ready, 1);
    if (op != WR && op != RD) begin
      chk("op_err", {err, err_code}, 3'b101);
      step(); in_valid = 1'b0; #1;
      chk("op_idle", {busy, in_ready}, 2'b01);
      step();
      return;
    end
    chk("op_noerr", err, 0);
    step();
    idle_wait(ga);
    in_valid = 1'b1; in_data = addr; #1;
    chk("addr_rdy", in_ready, 1);
    if (op == RD) begin
      if (!legal) begin
        chk("rd_badaddr_err", {err, err_code}, 3'b110);
        step(); in_valid = 1'b0; #1;
        chk("rd_bad_idle", {busy, out_valid, RdEn}, 3'b000);
        step();
        return;
      end
      chk("rd_addr_noerr", err, 0);
      step(); in_valid = 1'b0; #1;
      chk("rden", {RdEn, WrEn, in_ready}, 3'b100);
      chk("rd_address", Address, addr[3:0]);
      step(); #1;
      chk("capture", {RdEn, out_valid, in_ready, busy}, 4'b0001);
      step();
      for (int i = 0; i < stall; i++) begin
        #1;
        chk("send_hold", {out_valid, in_ready, out_data}, {2'b10, exp_mem[addr[3:0]]});
        step();
      end
      out_ready = 1'b1; #1;
      chk("send_hs", {out_valid, out_data}, {1'b1, exp_mem[addr[3:0]]});
      step(); out_ready = 1'b0; #1;
      chk("send_done", {out_valid, busy, in_ready}, 3'b001);
      step();
    end else begin
      chk("wr_addr_noerr", err, 0);
      step();
      idle_wait(gd);
      in_valid = 1'b1; in_data = data; #1;
      chk("data_rdy", in_ready, 1);
      if (!legal) begin
        chk("wr_badaddr_err", {err, err_code}, 3'b110);
        step(); in_valid = 1'b0; #1;
        chk("wr_bad_idle", {busy, WrEn}, 2'b00);
        step();
        return;
      end
      chk("data_noerr", err, 0);
      step(); in_valid = 1'b0; #1;
      chk("wren", {WrEn, RdEn, in_ready}, 3'b100);
      chk("wr_address", Address, addr[3:0]);
      chk("wr_data", WrData, data);
      exp_mem[addr[3:0]] = data;
      step(); #1;
      chk("wr_done", {busy, WrEn, in_ready}, 3'b001);
      step();
    end
  endtask

  initial begin
    logic [7:0] op, addr, data;
    RST = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step(); step(); #1;
    chk("rst_ctrl", {in_ready, busy, out_valid, WrEn, RdEn, err}, 6'b100000);
    chk("rst_data", {Address, WrData, out_data, err_code}, 22'h0);
    RST = 1'b0;
    step();

    // Directed frames
    run_frame(WR, 8'h05, 8'h3C, 0, 0, 0);
    run_frame(RD, 8'h05, 8'h00, 0, 0, 3);
    run_frame(8'h7F, 8'h00, 8'h00, 0, 0, 0);
    run_frame(WR, 8'h02, 8'h11, 0, 0, 0);
    run_frame(WR, 8'h25, 8'h99, 0, 0, 0);
    run_frame(RD, 8'hF0, 8'h00, 0, 0, 0);
    run_frame(RD, 8'h02, 8'h00, 0, 0, 0);

    // Timeout: 255 idle cycles after the opcode aborts the frame
    in_valid = 1'b1; in_data = RD; #1;
    step();
    idle_wait(254);
    #1;
    chk("to_err", {err, err_code, RdEn}, 4'b1110);
    step(); #1;
    chk("to_idle", {busy, in_ready}, 2'b01);
    step();
    // Byte arriving on the limit cycle wins
    run_frame(RD, 8'h05, 8'h00, 254, 0, 1);
    run_frame(WR, 8'h0E, 8'h5A, 2, 254, 0);

    // Reset while in GET_DATA
    in_valid = 1'b1; in_data = WR; #1; step();
    in_data = 8'h03; #1; step();
    RST = 1'b1; in_data = 8'h55; #1; step();
    RST = 1'b0; in_valid = 1'b0; #1;
    chk("rst_mid", {in_ready, busy, WrEn}, 3'b100);
    step();
    for (int i = 0; i < 3; i++) begin
      #1; chk("rst_no_wren", {WrEn, busy}, 2'b00); step();
    end
    run_frame(WR, 8'h03, 8'h44, 0, 0, 0);
    run_frame(RD, 8'h03, 8'h00, 0, 0, 0);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)      op = WR;
      else if (r < 8) op = RD;
      else begin
        op = 8'($urandom);
        while (op == WR || op == RD) op = 8'($urandom);
      end
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255))
                                         : 8'($urandom_range(0, 15));
      data = 8'($urandom);
      run_frame(op, addr, data, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3));
    end
    for (int a = 0; a < 16; a++) run_frame(RD, 8'(a), 8'h00, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
